// File: rtl/osd_glyph_fetch_arb.sv
`default_nettype none
// ============================================================================
// Module   : osd_glyph_fetch_arb
// Purpose  : Two-requester round-robin arbiter that fetches OSD glyph rows
//            from an external character ROM. A requester asks for one row,
//            or for a burst of every row of one glyph. It gets one ROM read
//            per clock. Each row read comes back as a one-cycle response.
// Ports    : clk, rst            - clock, asynchronous active-high reset
//            reqN_valid/code/row/burst, reqN_ready (N=0,1)
//                                - request handshake per requester
//            rom_addr            - registered ROM address {code,row}
//            rom_rd_data         - ROM data, one cycle after address sample
//            resp_valid/id/row/data/last
//                                - response strobe and payload
//            busy                - burst running or response in flight
// Revision : 1.0 - initial release
// ============================================================================
module osd_glyph_fetch_arb #(
    parameter int CODE_W     = 7,
    parameter int ROW_W      = 4,
    parameter int DATA_WIDTH = 9
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req0_valid,
    input  logic [CODE_W-1:0]         req0_code,
    input  logic [ROW_W-1:0]          req0_row,
    input  logic                      req0_burst,
    output logic                      req0_ready,
    input  logic                      req1_valid,
    input  logic [CODE_W-1:0]         req1_code,
    input  logic [ROW_W-1:0]          req1_row,
    input  logic                      req1_burst,
    output logic                      req1_ready,
    output logic [CODE_W+ROW_W-1:0]   rom_addr,
    input  logic [DATA_WIDTH-1:0]     rom_rd_data,
    output logic                      resp_valid,
    output logic                      resp_id,
    output logic [ROW_W-1:0]          resp_row,
    output logic [DATA_WIDTH-1:0]     resp_data,
    output logic                      resp_last,
    output logic                      busy
);

    localparam logic [ROW_W-1:0] c_ROW_LAST = {ROW_W{1'b1}};

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_BURST = 1'b1;

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;

    // Id of the most recent grant; the other requester wins the next tie.
    logic              r_last_grant;

    logic              w_pick1;
    logic              w_accept;
    logic [CODE_W-1:0] w_sel_code;
    logic [ROW_W-1:0]  w_sel_row;
    logic              w_sel_burst;

    // Burst context: glyph code, owner and the next row to issue.
    logic [CODE_W-1:0] r_burst_code;
    logic              r_burst_id;
    logic [ROW_W-1:0]  r_burst_row;

    // Metadata that travels with each address. The issue stage lines up with
    // rom_addr. The read stage lines up with the ROM access. Response regs
    // then capture rom_rd_data.
    logic              r_iss_valid;
    logic              r_iss_id;
    logic [ROW_W-1:0]  r_iss_row;
    logic              r_iss_last;
    logic              r_rd_valid;
    logic              r_rd_id;
    logic [ROW_W-1:0]  r_rd_row;
    logic              r_rd_last;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (w_accept && w_sel_burst) w_state_nxt = c_ST_BURST;
            // Leave on the edge that issues the final row.
            c_ST_BURST: if (r_burst_row == c_ROW_LAST) w_state_nxt = c_ST_IDLE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Grant logic. Ready is only given to a requester that is valid. On a
    // tie, the requester that was not granted last time wins.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        w_pick1    = 1'b0;
        w_accept   = 1'b0;
        if (r_state == c_ST_IDLE) begin
            w_pick1    = req1_valid & (~req0_valid | ~r_last_grant);
            w_accept   = req0_valid | req1_valid;
            req0_ready = req0_valid & ~w_pick1;
            req1_ready = w_pick1;
        end
    end

    assign w_sel_code  = w_pick1 ? req1_code  : req0_code;
    assign w_sel_row   = w_pick1 ? req1_row   : req0_row;
    assign w_sel_burst = w_pick1 ? req1_burst : req0_burst;

    assign busy = (r_state == c_ST_BURST) | r_iss_valid | r_rd_valid;

    // ------------------------------------------------------------ datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= 1'b1;
            rom_addr     <= '0;
            r_burst_code <= '0;
            r_burst_id   <= 1'b0;
            r_burst_row  <= '0;
            r_iss_valid  <= 1'b0;
            r_iss_id     <= 1'b0;
            r_iss_row    <= '0;
            r_iss_last   <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_rd_id      <= 1'b0;
            r_rd_row     <= '0;
            r_rd_last    <= 1'b0;
            resp_valid   <= 1'b0;
            resp_id      <= 1'b0;
            resp_row     <= '0;
            resp_data    <= '0;
            resp_last    <= 1'b0;
        end else begin
            r_iss_valid <= 1'b0;
            if (r_state == c_ST_BURST) begin
                rom_addr    <= {r_burst_code, r_burst_row};
                r_iss_valid <= 1'b1;
                r_iss_id    <= r_burst_id;
                r_iss_row   <= r_burst_row;
                r_iss_last  <= (r_burst_row == c_ROW_LAST);
                r_burst_row <= r_burst_row + 1'b1;
            end else if (w_accept) begin
                r_last_grant <= w_pick1;
                r_iss_valid  <= 1'b1;
                r_iss_id     <= w_pick1;
                if (w_sel_burst) begin
                    rom_addr     <= {w_sel_code, {ROW_W{1'b0}}};
                    r_burst_code <= w_sel_code;
                    r_burst_id   <= w_pick1;
                    r_burst_row  <= ROW_W'(1);
                    r_iss_row    <= '0;
                    r_iss_last   <= 1'b0;
                end else begin
                    rom_addr   <= {w_sel_code, w_sel_row};
                    r_iss_row  <= w_sel_row;
                    r_iss_last <= 1'b1;
                end
            end

            r_rd_valid <= r_iss_valid;
            r_rd_id    <= r_iss_id;
            r_rd_row   <= r_iss_row;
            r_rd_last  <= r_iss_last;

            resp_valid <= r_rd_valid;
            if (r_rd_valid) begin
                resp_id   <= r_rd_id;
                resp_row  <= r_rd_row;
                resp_last <= r_rd_last;
                resp_data <= rom_rd_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/osd_glyph_fetch_arb.md
OSD_GLYPH_FETCH_ARB -- requirements
Module: osd_glyph_fetch_arb

Interface
REQ-001 SHALL have parameter CODE_W, default 7, character-code width (128 glyphs).
REQ-002 SHALL have parameter ROW_W, default 4, glyph-row index width (16 rows per glyph).
REQ-003 SHALL have parameter DATA_WIDTH, default 9, glyph-row bitmap width (matches char ROM word).
REQ-004 SHALL have port clk  input  1  single clock for all logic and the char ROM.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports reqN_valid  input  1  requester N (N=0,1) request valid.
REQ-007 SHALL have ports reqN_code  input  CODE_W  requester N character code.
REQ-008 SHALL have ports reqN_row  input  ROW_W  requester N row (ignored when reqN_burst=1).
REQ-009 SHALL have ports reqN_burst  input  1  1 = fetch all 2**ROW_W rows of the glyph.
REQ-010 SHALL have ports reqN_ready  output  1  requester N accepted this cycle.
REQ-011 SHALL have port rom_addr  output  CODE_W+ROW_W  char ROM address, registered, {code,row}.
REQ-012 SHALL have port rom_rd_data  input  DATA_WIDTH  char ROM read data, valid 1 cycle after the ROM samples rom_addr (no output register).
REQ-013 SHALL have port resp_valid  output  1  response strobe, one cycle per row.
REQ-014 SHALL have port resp_id  output  1  requester that owns the response.
REQ-015 SHALL have port resp_row  output  ROW_W  row index of resp_data.
REQ-016 SHALL have port resp_data  output  DATA_WIDTH  glyph-row bitmap.
REQ-017 SHALL have port resp_last  output  1  final row of a burst, or any single-row response.
REQ-018 SHALL have port busy  output  1  high while in BURST or any response in flight.

Function
REQ-019 SHALL implement states IDLE and BURST.
REQ-020 In IDLE, reqN_ready SHALL be combinational grant: sole valid requester granted; both valid -> requester other than last_grant granted (round-robin).
REQ-021 In BURST, req0_ready and req1_ready SHALL be 0.
REQ-022 On accept (valid & ready) at edge E, last_grant SHALL update to the granted id at E.
REQ-023 Single-row accept at E SHALL load rom_addr={code,row} at E and stay IDLE.
REQ-024 Burst accept at E SHALL load rom_addr={code,0} at E, latch code and id, enter BURST.
REQ-025 In BURST, rom_addr row SHALL increment by 1 per edge (rows 1..2**ROW_W-1 at E+1..E+15), returning to IDLE at the edge issuing the last row; next accept possible at E+16.
REQ-026 Each issued address SHALL yield exactly one response: resp_valid high for the cycle after edge E+2 (issue edge + 2), carrying resp_data=rom_rd_data captured at that edge, with id and row pipelined alongside.
REQ-027 resp_last SHALL be 1 for single-row responses and for row 2**ROW_W-1 of a burst, else 0.
REQ-028 Sustained throughput SHALL be one ROM read per clock; no response backpressure exists.
REQ-029 rom_addr SHALL hold its last value when no address is issued.
REQ-030 Request inputs SHALL be ignored while not ready; requesters hold valid and payload until ready.

Reset
REQ-031 While rst=1, state=IDLE, last_grant=1 (req0 wins first tie), rom_addr=0, resp_valid=0, resp_id=0, resp_row=0, resp_data=0, resp_last=0, busy=0, all in-flight pipeline valids cleared.
REQ-032 rst asserted mid-burst SHALL abort the burst with no further responses after reset release.
REQ-033 rst SHALL also drive the char ROM rst input.

Verification
REQ-034 Single: req0 valid, code 0x41, row 5, burst 0 -> req0_ready same cycle; rom_addr=0x415; resp_valid 2 cycles after accept with id 0, row 5, last 1, data=ROM[0x415].
REQ-035 Tie after reset: both single requests valid continuously -> grants alternate 0,1,0,1; one response per cycle, ids alternate.
REQ-036 Burst: req1 burst, code 0x30 -> 16 consecutive responses, id 1, rows 0..15, data=ROM[0x300..0x30F], last only on row 15; req0 ready held 0 for 15 cycles after accept.
REQ-037 Burst vs pending single: req0 single waiting during req1 burst -> req0 granted at first IDLE cycle, its response directly follows row 15.
REQ-038 Reset mid-burst at row 7 -> all outputs at reset values, no resp_valid after release until a new accept.
REQ-039 Boundary: code 0x7F row 15 single -> rom_addr=0x7FF, resp_row=15; burst on 0x7F ends without address wrap into code 0.
